// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - shared state encoding and display constants for the round controller
package round_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    RESULT = 2'd2,
    OVER   = 2'd3
  } round_state_t;

  localparam logic [4:0] MAX_PROGRESS = 5'd10;
  localparam logic [9:0] BLINK_A      = 10'h2AA;
  localparam logic [9:0] BLINK_B      = 10'h155;

endpackage

// File: rtl/progress_bar_encode.sv
// rtl/progress_bar_encode.sv - clamped 5-bit progress to 10-bit thermometer bar
module progress_bar_encode
  import round_pkg::*;
(
  input  logic [4:0] progress,
  output logic [9:0] bar
);

  logic [4:0] level;

  always_comb begin
    level = (progress > MAX_PROGRESS) ? MAX_PROGRESS : progress;
    bar   = '0;
    for (int i = 0; i < 10; i++) begin
      bar[i] = (5'(i) < level);
    end
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - round FSM: LED bar, warning blink, timeout, lives and score
module round_timer_ctrl
  import round_pkg::*;
#(
  parameter int LIVES   = 3,
  parameter int HOLD    = 2,
  parameter int WARN    = 3,
  parameter int SCORE_W = 8
) (
  input  logic               secclk,
  input  logic               resetn,
  input  logic [4:0]         progress,
  input  logic               start,
  input  logic               answer_correct,
  input  logic               answer_wrong,
  output logic [9:0]         ledbar,
  output logic               warn,
  output logic               new_round,
  output logic               timeout,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int              HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  round_state_t      state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              armed;
  logic              last_win;
  logic [9:0]        thermo;
  logic              warn_zone;
  logic              expired;
  logic              round_end;

  progress_bar_encode u_encode (
    .progress (progress),
    .bar      (thermo)
  );

  assign warn_zone = (progress != 5'd0) && (progress <= 5'(WARN));
  // armed masks the stale zero the countdown still shows during its reload
  assign expired   = armed && (progress == 5'd0);
  assign round_end = answer_correct || answer_wrong || expired;

  always_ff @(posedge secclk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      armed     <= 1'b0;
      last_win  <= 1'b0;
      ledbar    <= '0;
      warn      <= 1'b0;
      new_round <= 1'b0;
      timeout   <= 1'b0;
      lives     <= 3'(LIVES);
      score     <= '0;
      game_over <= 1'b0;
    end else begin
      new_round <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PLAY;
            new_round <= 1'b1;
            armed     <= 1'b0;
          end
        end
        PLAY: begin
          if (progress != 5'd0) armed <= 1'b1;
          if (round_end) begin
            state    <= RESULT;
            hold_cnt <= '0;
            warn     <= 1'b0;
            last_win <= answer_correct;
            ledbar   <= answer_correct ? '1 : '0;
            timeout  <= !answer_correct && !answer_wrong;
            if (answer_correct) begin
              if (score != '1) score <= score + SCORE_W'(1);
            end else if (lives != 3'd0) begin
              lives <= lives - 3'd1;
            end
          end else begin
            ledbar <= thermo;
            warn   <= warn_zone ? !warn : 1'b0;
          end
        end
        RESULT: begin
          ledbar <= last_win ? '1 : '0;
          if (hold_cnt == HOLD_LAST) begin
            if (lives == 3'd0) begin
              state     <= OVER;
              game_over <= 1'b1;
              ledbar    <= BLINK_A;
            end else begin
              state     <= PLAY;
              new_round <= 1'b1;
              armed     <= 1'b0;
              ledbar    <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        OVER: begin
          if (start) begin
            state     <= PLAY;
            lives     <= 3'(LIVES);
            score     <= '0;
            game_over <= 1'b0;
            new_round <= 1'b1;
            armed     <= 1'b0;
            ledbar    <= '0;
          end else begin
            ledbar <= (ledbar == BLINK_A) ? BLINK_B : BLINK_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - randomized and directed bench with a behavioural round model
module tb_round_timer_ctrl;

  logic       secclk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] progress = '0;
  logic       start = 1'b0;
  logic       answer_correct = 1'b0;
  logic       answer_wrong = 1'b0;

  logic [9:0] ledbar, ledbar2;
  logic       warn, warn2, new_round, new_round2, timeout, timeout2, game_over, game_over2;
  logic [2:0] lives, lives2;
  logic [7:0] score;
  logic [1:0] score2;

  int n_checks = 0;
  int n_errors = 0;

  round_timer_ctrl dut (
    .secclk(secclk), .resetn(resetn), .progress(progress), .start(start),
    .answer_correct(answer_correct), .answer_wrong(answer_wrong),
    .ledbar(ledbar), .warn(warn), .new_round(new_round), .timeout(timeout),
    .lives(lives), .score(score), .game_over(game_over)
  );

  round_timer_ctrl #(.SCORE_W(2)) dut2 (
    .secclk(secclk), .resetn(resetn), .progress(progress), .start(start),
    .answer_correct(answer_correct), .answer_wrong(answer_wrong),
    .ledbar(ledbar2), .warn(warn2), .new_round(new_round2), .timeout(timeout2),
    .lives(lives2), .score(score2), .game_over(game_over2)
  );

  always #5 secclk = ~secclk;

  // Behavioural model: what the outputs must show after each rising edge
  localparam int M_IDLE = 0, M_PLAY = 1, M_RESULT = 2, M_OVER = 3;
  int         m_mode, m_lives, m_wins, m_hold_left;
  bit         m_armed, m_win, m_warn, m_new_round, m_timeout, m_over;
  logic [9:0] m_led;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] bar_of(input int p);
    int n;
    n = (p > 10) ? 10 : p;
    return 10'((1 << n) - 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = 3; m_wins = 0; m_hold_left = 0;
    m_armed = 0; m_win = 0; m_warn = 0; m_new_round = 0; m_timeout = 0; m_over = 0;
    m_led = '0;
  endtask

  task automatic model_enter_result(input bit win);
    m_mode = M_RESULT; m_hold_left = 2; m_win = win; m_warn = 0;
    m_led = win ? 10'h3FF : 10'h000;
  endtask

  task automatic model_step(input bit st, input bit ac, input bit aw, input int p);
    m_new_round = 0; m_timeout = 0;
    if (m_mode == M_IDLE) begin
      if (st) begin m_mode = M_PLAY; m_new_round = 1; m_armed = 0; end
    end else if (m_mode == M_PLAY) begin
      if (ac) begin
        m_wins++; model_enter_result(1);
      end else if (aw) begin
        if (m_lives > 0) m_lives--;
        model_enter_result(0);
      end else if (m_armed && p == 0) begin
        m_timeout = 1;
        if (m_lives > 0) m_lives--;
        model_enter_result(0);
      end else begin
        m_led  = bar_of(p);
        m_warn = (p >= 1 && p <= 3) ? !m_warn : 1'b0;
      end
      if (p != 0) m_armed = 1;
    end else if (m_mode == M_RESULT) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        if (m_lives == 0) begin m_mode = M_OVER; m_over = 1; m_led = 10'h2AA; end
        else begin m_mode = M_PLAY; m_new_round = 1; m_armed = 0; m_led = '0; end
      end
    end else begin
      if (st) begin
        m_mode = M_PLAY; m_lives = 3; m_wins = 0; m_over = 0;
        m_new_round = 1; m_armed = 0; m_led = '0;
      end else begin
        m_led = (m_led == 10'h2AA) ? 10'h155 : 10'h2AA;
      end
    end
  endtask

  task automatic check_all();
    chk("ledbar", 32'(ledbar), 32'(m_led));
    chk("warn", 32'(warn), 32'(m_warn));
    chk("new_round", 32'(new_round), 32'(m_new_round));
    chk("timeout", 32'(timeout), 32'(m_timeout));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("score", 32'(score), (m_wins > 255) ? 32'd255 : 32'(m_wins));
    chk("game_over", 32'(game_over), 32'(m_over));
    chk("ledbar_w2", 32'(ledbar2), 32'(m_led));
    chk("lives_w2", 32'(lives2), 32'(m_lives));
    chk("score_w2", 32'(score2), (m_wins > 3) ? 32'd3 : 32'(m_wins));
  endtask

  task automatic step(input bit st, input bit ac, input bit aw, input int p);
    start = st; answer_correct = ac; answer_wrong = aw; progress = 5'(p);
    @(posedge secclk);
    model_step(st, ac, aw, p);
    #1;
    check_all();
    start = 0; answer_correct = 0; answer_wrong = 0;
  endtask

  initial begin
    int rp;
    model_reset();
    repeat (2) @(posedge secclk);
    @(negedge secclk);
    check_all();
    chk("reset_lives", 32'(lives), 32'd3);
    chk("reset_ledbar", 32'(ledbar), 32'd0);
    resetn = 1'b1;

    // countdown 10..0 ends in timeout
    step(1, 0, 0, 0);
    chk("t1_new_round", 32'(new_round), 32'd1);
    for (int p = 10; p >= 1; p--) begin
      step(0, 0, 0, p);
      if (p == 10) chk("t1_bar10", 32'(ledbar), 32'h3FF);
      if (p == 9)  chk("t1_bar9", 32'(ledbar), 32'h1FF);
      if (p == 1)  chk("t1_bar1", 32'(ledbar), 32'h001);
      if (p == 3)  chk("t1_warn3", 32'(warn), 32'd1);
      if (p == 2)  chk("t1_warn2", 32'(warn), 32'd0);
      if (p == 4)  chk("t1_warn4", 32'(warn), 32'd0);
    end
    step(0, 0, 0, 0);
    chk("t1_timeout", 32'(timeout), 32'd1);
    chk("t1_lives", 32'(lives), 32'd2);

    // stale zero after reload must not time out
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t2_new_round", 32'(new_round), 32'd1);
    step(0, 0, 0, 0);
    chk("t2_no_timeout_a", 32'(timeout), 32'd0);
    step(0, 0, 0, 0);
    chk("t2_no_timeout_b", 32'(timeout), 32'd0);
    step(0, 0, 0, 10);
    chk("t2_lives", 32'(lives), 32'd2);

    // correct answer beats simultaneous timeout
    step(0, 0, 0, 5);
    step(0, 1, 0, 0);
    chk("t3_score", 32'(score), 32'd1);
    chk("t3_no_timeout", 32'(timeout), 32'd0);
    chk("t3_bar_a", 32'(ledbar), 32'h3FF);
    step(0, 0, 0, 0);
    chk("t3_bar_b", 32'(ledbar), 32'h3FF);
    step(0, 0, 0, 0);
    chk("t3_new_round", 32'(new_round), 32'd1);

    // run lives down, then restart from OVER
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1, 7); step(0, 0, 0, 0); step(0, 0, 0, 0);
    end
    chk("t4a_over", 32'(game_over), 32'd1);
    chk("t4a_blink", 32'(ledbar), 32'h2AA);
    step(1, 0, 0, 0);
    chk("t5_lives", 32'(lives), 32'd3);
    chk("t5_score", 32'(score), 32'd0);
    chk("t5_over", 32'(game_over), 32'd0);
    chk("t5_new_round", 32'(new_round), 32'd1);

    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 8);
      chk("t4_lives", 32'(lives), 32'(2 - k));
      step(0, 0, 0, 0); step(0, 0, 0, 0);
    end
    chk("t4_over", 32'(game_over), 32'd1);
    step(0, 1, 0, 0);
    chk("t4_ignored_score", 32'(score), 32'd0);
    chk("t4_blink_b", 32'(ledbar), 32'h155);
    step(0, 0, 1, 0);
    chk("t4_ignored_lives", 32'(lives), 32'd0);
    step(1, 0, 0, 0);

    // saturation on the narrow-score instance
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 6); step(0, 0, 0, 0); step(0, 0, 0, 0);
    end
    chk("t6_score_w2", 32'(score2), 32'd3);
    chk("t6_score_w8", 32'(score), 32'd4);

    // asynchronous reset in the middle of RESULT
    step(0, 0, 1, 6);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_lives", 32'(lives), 32'd3);
    @(posedge secclk); #1;
    check_all();
    @(negedge secclk);
    resetn = 1'b1;

    // randomized play against the model
    rp = 0;
    for (int c = 0; c < 3000; c++) begin
      bit st, ac, aw;
      st = ($urandom_range(0, 39) == 0);
      ac = ($urandom_range(0, 29) == 0);
      aw = ($urandom_range(0, 29) == 0);
      if (m_new_round) rp = ($urandom_range(0, 1) == 0) ? 0 : 10;
      else if ($urandom_range(0, 5) == 0) rp = $urandom_range(0, 15);
      else if (rp > 10) rp = 10;
      else if (rp > 0 && $urandom_range(0, 1) == 0) rp = rp - 1;
      step(st, ac, aw, rp);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
